// File: rtl/fft_stage_controller.sv
// Stage sequencer for the 32-point radix-2 DIT FFT core: captures a frame, walks
// the five butterfly stages (issue, wait BF_LAT, write back) and hands the result off.
module fft_stage_controller #(
  parameter int BF_LAT = 2,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             flush,
  output logic             load_en,
  output logic [2:0]       SB,
  output logic             bf_en,
  output logic             reg_en,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LAST   = 4'(BF_LAT - 1);
  localparam logic [2:0] LAST_STAGE = 3'd4;

  state_t           state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]       sb_q, sb_d;
  logic             bf_en_q, bf_en_d;
  logic             reg_en_q, reg_en_d;
  logic             busy_q, busy_d;
  logic             done_valid_q, done_valid_d;

  // The start handshake is combinational and held off while reset is asserted.
  assign start_ready = RST & (state_q == IDLE) & ~flush;
  assign load_en     = start_valid & start_ready;

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d = ISSUE;
          stage_d = 3'd0;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LAST;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = DONE;
            stage_d = 3'd0;
          end else begin
            stage_d = stage_q + 3'd1;
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (done_valid_q && done_ready) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every handshake and discards the in-flight frame.
    if (flush) begin
      state_d     = IDLE;
      stage_d     = 3'd0;
      cnt_d       = 4'd0;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    bf_en_d      = (state_d == ISSUE);
    reg_en_d     = (state_d == WAIT) && (cnt_d == 4'd0);
    sb_d         = ((state_d == ISSUE) || (state_d == WAIT)) ? stage_d : 3'd0;
    busy_d       = (state_d != IDLE);
    done_valid_d = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      stage_q      <= 3'd0;
      cnt_q        <= 4'd0;
      frame_cnt_q  <= '0;
      sb_q         <= 3'd0;
      bf_en_q      <= 1'b0;
      reg_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      sb_q         <= sb_d;
      bf_en_q      <= bf_en_d;
      reg_en_q     <= reg_en_d;
      busy_q       <= busy_d;
      done_valid_q <= done_valid_d;
    end
  end

  assign SB         = sb_q;
  assign bf_en      = bf_en_q;
  assign reg_en     = reg_en_q;
  assign busy       = busy_q;
  assign done_valid = done_valid_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
